// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared constants, state encoding and helpers for pipe_stage_skid
package pipe_stage_skid_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// rtl/pipe_stage_skid_slot.sv - stage_slot: one {valid, pc, data} holding register with load and clear
module stage_slot #(
    parameter int                DATA_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter logic [PC_W-1:0]   RST_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [PC_W-1:0]   pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_DATA;
            pc_q    <= RST_PC;
        end else if (clear_i) begin
            // Payload is left alone; only the valid bit matters once cleared.
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - 2-entry skid pipeline register with flush and bubbles; PIPE_STAGE_PERF_EN adds counters
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                PC_W   = 32,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP),
    parameter logic [PC_W-1:0]   PC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);

    state_e state_q;

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [PC_W-1:0]   main_pc, skid_pc;

    logic              accept, drain;
    logic              main_load, main_from_skid, main_clr;
    logic              skid_load, skid_clr;
    logic [DATA_W-1:0] main_din;
    logic [PC_W-1:0]   main_pin;

    // in_ready depends only on the SKID valid flop, never on out_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    if (accept && drain)  main_load = 1'b1;
                    else if (accept)      skid_load = 1'b1;
                    else if (drain)       main_clr  = 1'b1;
                end
                ST_TWO: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_din = main_from_skid ? skid_data : in_data;
    assign main_pin = main_from_skid ? skid_pc   : in_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_q <= ST_TWO;
                    else if (!accept && drain) state_q <= ST_EMPTY;
                end
                ST_TWO:   if (drain) state_q <= ST_ONE;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    stage_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .RST_DATA(BUBBLE),
        .RST_PC  (PC_RST)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (main_load),
        .clear_i(main_clr),
        .data_i (main_din),
        .pc_i   (main_pin),
        .valid_o(main_valid),
        .data_o (main_data),
        .pc_o   (main_pc)
    );

    stage_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .RST_DATA(BUBBLE),
        .RST_PC  (PC_RST)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (skid_load),
        .clear_i(skid_clr),
        .data_i (in_data),
        .pc_i   (in_pc),
        .valid_o(skid_valid),
        .data_o (skid_data),
        .pc_o   (skid_pc)
    );

    // Downstream sees a NOP whenever the stage is empty, as the legacy register did.
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : BUBBLE;
    assign out_pc    = main_valid ? main_pc   : PC_RST;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (main_valid && !out_ready) stall_cnt_q  <= sat_inc(stall_cnt_q);
            if (!main_valid)              bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    int n_checks;
    int n_pass;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vld"},  {31'd0, out_valid}, 32'd0);
        check({tag, "_data"}, out_data, 32'h0000_0013);
        check({tag, "_pc"},   out_pc, 32'd0);
        check({tag, "_rdy"},  {31'd0, in_ready}, 32'd1);
    endtask

    logic [31:0] s_data [4];
    logic [31:0] s_pc   [4];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        s_data[0] = 32'h11; s_data[1] = 32'h22; s_data[2] = 32'h33; s_data[3] = 32'h44;
        s_pc[0]   = 32'h0;  s_pc[1]   = 32'h4;  s_pc[2]   = 32'h8;  s_pc[3]   = 32'hC;

        // reset and idle
        tick();
        tick();
        check_idle("rst");
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_bubble", bubble_cnt, 32'd0);
        rst = 1'b1;
        tick();
        check_idle("idle");

        // streaming, out_ready held high
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s_data[i];
            in_pc    = s_pc[i];
            tick();
            check($sformatf("st_rdy%0d", i),  {31'd0, in_ready}, 32'd1);
            check($sformatf("st_vld%0d", i),  {31'd0, out_valid}, 32'd1);
            check($sformatf("st_data%0d", i), out_data, s_data[i]);
            check($sformatf("st_pc%0d", i),   out_pc, s_pc[i]);
        end
        in_valid = 1'b0;
        tick();
        check("st_end_vld", {31'd0, out_valid}, 32'd0);

        // stall into skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA0;
        in_pc     = 32'h100;
        tick();
        check("sk_a_data", out_data, 32'hA0);
        check("sk_a_rdy", {31'd0, in_ready}, 32'd1);
        in_data = 32'hB0;
        in_pc   = 32'h104;
        tick();
        check("sk_two_data", out_data, 32'hA0);
        check("sk_two_pc", out_pc, 32'h100);
        check("sk_two_rdy", {31'd0, in_ready}, 32'd0);
        in_data = 32'hD0;
        in_pc   = 32'h108;
        tick();
        check("sk_hold_data", out_data, 32'hA0);
        check("sk_hold_rdy", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("sk_b_vld", {31'd0, out_valid}, 32'd1);
        check("sk_b_data", out_data, 32'hB0);
        check("sk_b_pc", out_pc, 32'h104);
        check("sk_b_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        check("sk_end_vld", {31'd0, out_valid}, 32'd0);

        // flush in TWO with simultaneous input and drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hE0;
        in_pc     = 32'h40;
        tick();
        in_data = 32'hE1;
        in_pc   = 32'h44;
        tick();
        check("fl_two_rdy", {31'd0, in_ready}, 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hC0;
        in_pc     = 32'h48;
        tick();
        check_idle("fl");
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl_after_vld", {31'd0, out_valid}, 32'd0);
        check("fl_after_data", out_data, 32'h0000_0013);

        // async reset while in TWO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hF0;
        in_pc     = 32'h200;
        tick();
        in_data = 32'hF1;
        in_pc   = 32'h204;
        tick();
        in_valid = 1'b0;
        check("ar_two_rdy", {31'd0, in_ready}, 32'd0);
        check("ar_two_data", out_data, 32'hF0);
        #2;
        rst = 1'b0;
        #1;
        check_idle("ar");

        // perf: 1 empty edge, 3 stalled edges, 1 drain, 1 empty edge
        #2;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        in_pc     = 32'h300;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("pf_data", out_data, 32'h55);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        check("pf_vld", {31'd0, out_valid}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
        check("pf_stall", stall_cnt, 32'd3);
        check("pf_bubble", bubble_cnt, 32'd2);
`else
        check("pf_stall", stall_cnt, 32'd0);
        check("pf_bubble", bubble_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
